reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, data width of every register and read/write port.
REQ-002 The block SHALL have parameter ZERO_REG, default 31, index of the hardwired-zero register (XZR).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; clears all state while low.
REQ-005 read_reg1  input  5  register index for port 1 (ALU operand a).
REQ-006 read_reg2  input  5  register index for port 2 (ALU operand b).
REQ-007 rd_en  input  1  when high, sample both read indices at this edge.
REQ-008 write_reg  input  5  register index for the write port.
REQ-009 write_data  input  DATA_W  value to write (ALU result or memory load data).
REQ-010 reg_write  input  1  write enable for the write port.
REQ-011 read_data1  output  DATA_W  registered contents of read_reg1.
REQ-012 read_data2  output  DATA_W  registered contents of read_reg2.
REQ-013 rd_valid  output  1  high for one cycle when read_data1/2 carry a fresh read.

Function
REQ-014 The block SHALL hold 32 registers of DATA_W bits, indices 0-31.
REQ-015 On a clk edge with reg_write=1 and write_reg!=ZERO_REG, the block SHALL store write_data into register write_reg.
REQ-016 A write to ZERO_REG SHALL be discarded; register ZERO_REG SHALL always read as 0.
REQ-017 Reads SHALL be synchronous: on a clk edge with rd_en=1, read_data1/2 SHALL load the addressed contents, visible one cycle later (latency 1).
REQ-018 rd_valid SHALL be set to 1 on a clk edge with rd_en=1 and cleared to 0 on a clk edge with rd_en=0.
REQ-019 With rd_en=0, read_data1/2 SHALL hold their previous values.
REQ-020 Write-read collision: when reg_write=1, rd_en=1 and read_regN==write_reg!=ZERO_REG on the same edge, read_dataN SHALL load write_data (write-first bypass).
REQ-021 Collision on ZERO_REG: read_dataN SHALL load 0 regardless of write_data.
REQ-022 Both read ports addressing the same register SHALL return identical values, including under bypass.
REQ-023 Indices are 5 bits; no out-of-range condition exists and no index wrap handling is needed.
REQ-024 Write and read on the same edge to different registers SHALL both complete; the read returns the pre-edge contents of its register.

Reset
REQ-025 While reset=0, all 32 registers, read_data1, read_data2 SHALL be 0 and rd_valid SHALL be 0, independent of clk.
REQ-026 Deassertion of reset SHALL take effect at the next clk edge; no write or read SHALL occur on an edge at which reset is low.
REQ-027 Reset asserted mid-sequence SHALL abandon any pending read/write; the first post-reset read of any register SHALL return 0.

Verification
REQ-028 Reset, then rd_en=1, read_reg1=5, read_reg2=31 -> next cycle read_data1=0, read_data2=0, rd_valid=1.
REQ-029 Write reg 3 = 64'h0000_0000_DEAD_BEEF; next cycle read reg 3 on both ports -> read_data1=read_data2=64'hDEADBEEF one cycle later.
REQ-030 Same edge: reg_write=1, write_reg=7, write_data=64'h1234, rd_en=1, read_reg1=7, read_reg2=8 -> read_data1=64'h1234 (bypass), read_data2=0.
REQ-031 Write reg 31 = 64'hFFFF_FFFF_FFFF_FFFF, with a same-edge read of 31 and a later read of 31 -> both return 0.
REQ-032 Write regs 1..30 with index*64'h0101; pulse reset low between clk edges -> all outputs 0 immediately; reads of regs 1..30 return 0.
REQ-033 rd_en=1 one cycle, then rd_en=0 three cycles while writing the read register -> rd_valid 1 then 0; read_data holds the old value.

Source files
------------

// File: rtl/reg_file.sv
// 32-entry register file with one write port and two registered read ports.
// Write-first bypass on same-edge collisions; index ZERO_REG always reads as 0.
module reg_file #(
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    input  logic              rd_en,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              rd_valid
);

    localparam int         NREGS = 32;
    localparam logic [4:0] ZR    = 5'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic              rd_valid_q;
    logic              wr_en;

    // The zero register is never written, so its storage stays at its reset value.
    assign wr_en = reg_write && (write_reg != ZR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[write_reg] <= write_data;
        end
    end

    // Read muxes: bypass the in-flight write, then force the zero register last.
    always_comb begin
        rdata1_d = regs_q[read_reg1];
        if (wr_en && (write_reg == read_reg1)) rdata1_d = write_data;
        if (read_reg1 == ZR)                   rdata1_d = '0;

        rdata2_d = regs_q[read_reg2];
        if (wr_en && (write_reg == read_reg2)) rdata2_d = write_data;
        if (read_reg2 == ZR)                   rdata2_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rdata1_q <= rdata1_d;
                rdata2_q <= rdata2_d;
            end
        end
    end

    assign read_data1 = rdata1_q;
    assign read_data2 = rdata2_q;
    assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (DATA_W=64, ZERO_REG=31).
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic        rd_en, reg_write;
    logic [63:0] write_data;
    logic [63:0] read_data1, read_data2;
    logic        rd_valid;

    int tests = 0;
    int fails = 0;

    reg_file #(.DATA_W(64), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .rd_en(rd_en),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data1(read_data1), .read_data2(read_data2), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                         input logic re, input logic [4:0] r1, input logic [4:0] r2);
        reg_write  = we;
        write_reg  = wr;
        write_data = wd;
        rd_en      = re;
        read_reg1  = r1;
        read_reg2  = r2;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_rd1", read_data1, 64'h0);
        chk("rst_rd2", read_data2, 64'h0);
        chk("rst_vld", {63'h0, rd_valid}, 64'h0);
        step();
        reset = 1'b1;

        // Post-reset read of an ordinary register and the zero register
        drive(0, 0, 0, 1, 5, 31);
        step();
        chk("r028_rd1", read_data1, 64'h0);
        chk("r028_rd2", read_data2, 64'h0);
        chk("r028_vld", {63'h0, rd_valid}, 64'h1);

        // Write then read on both ports
        drive(1, 3, 64'h0000_0000_DEAD_BEEF, 0, 0, 0);
        step();
        chk("r029_vld0", {63'h0, rd_valid}, 64'h0);
        drive(0, 0, 0, 1, 3, 3);
        step();
        chk("r029_rd1", read_data1, 64'hDEAD_BEEF);
        chk("r029_rd2", read_data2, 64'hDEAD_BEEF);
        chk("r029_vld", {63'h0, rd_valid}, 64'h1);

        // Bypass on port 1, untouched register on port 2
        drive(1, 7, 64'h1234, 1, 7, 8);
        step();
        chk("r030_rd1", read_data1, 64'h1234);
        chk("r030_rd2", read_data2, 64'h0);
        drive(0, 0, 0, 1, 8, 7);
        step();
        chk("r030_chk_rd1", read_data1, 64'h0);
        chk("r030_chk_rd2", read_data2, 64'h1234);

        // Write to one register while reading two others: pre-edge contents
        drive(1, 9, 64'hAAAA, 1, 3, 7);
        step();
        chk("r024_rd1", read_data1, 64'hDEAD_BEEF);
        chk("r024_rd2", read_data2, 64'h1234);

        // Bypass on port 2 only
        drive(1, 3, 64'h77, 1, 7, 3);
        step();
        chk("byp2_rd1", read_data1, 64'h1234);
        chk("byp2_rd2", read_data2, 64'h77);

        // Both ports on the bypassed register
        drive(1, 10, 64'hABCD, 1, 10, 10);
        step();
        chk("r022_rd1", read_data1, 64'hABCD);
        chk("r022_rd2", read_data2, 64'hABCD);

        // Zero register: same-edge collision and later read
        drive(1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 31, 31);
        step();
        chk("r031_byp_rd1", read_data1, 64'h0);
        chk("r031_byp_rd2", read_data2, 64'h0);
        drive(0, 0, 0, 1, 31, 31);
        step();
        chk("r031_late_rd1", read_data1, 64'h0);
        chk("r031_late_rd2", read_data2, 64'h0);

        // rd_en one cycle, then held low while the read register is rewritten
        drive(0, 0, 0, 1, 3, 7);
        step();
        chk("r033_vld1", {63'h0, rd_valid}, 64'h1);
        chk("r033_rd1", read_data1, 64'h77);
        for (int i = 1; i <= 3; i++) begin
            drive(1, 3, 64'h100 + 64'(i), 0, 3, 7);
            step();
            chk("r033_vld0", {63'h0, rd_valid}, 64'h0);
            chk("r033_hold1", read_data1, 64'h77);
            chk("r033_hold2", read_data2, 64'h1234);
        end
        drive(0, 0, 0, 1, 3, 3);
        step();
        chk("r033_new", read_data1, 64'h103);

        // Fill regs 1..30, spot-check, then pulse reset between edges
        for (int i = 1; i <= 30; i++) begin
            drive(1, 5'(i), 64'(i) * 64'h0101, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 1, 1, 30);
        step();
        chk("r032_pre_rd1", read_data1, 64'h0101);
        chk("r032_pre_rd2", read_data2, 64'h1E1E);
        #2 reset = 1'b0;
        #1;
        chk("r032_rst_rd1", read_data1, 64'h0);
        chk("r032_rst_rd2", read_data2, 64'h0);
        chk("r032_rst_vld", {63'h0, rd_valid}, 64'h0);
        #1 reset = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            drive(0, 0, 0, 1, 5'(i), 5'(31 - i));
            step();
            chk("r032_post_rd1", read_data1, 64'h0);
            chk("r032_post_rd2", read_data2, 64'h0);
        end

        // No write or read on an edge while reset is held low
        reset = 1'b0;
        drive(1, 4, 64'hFF, 1, 4, 4);
        step();
        chk("r026_vld", {63'h0, rd_valid}, 64'h0);
        chk("r026_rd1", read_data1, 64'h0);
        reset = 1'b1;
        drive(0, 0, 0, 1, 4, 1);
        step();
        chk("r026_rd_after", read_data1, 64'h0);
        chk("r026_vld_after", {63'h0, rd_valid}, 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
